alu_issue_sequencer: RTL and testbench

Issue and writeback controller for the 4-bit decode-and-execute datapath. Accepts encoded instructions over a valid/ready handshake and reads operands from an internal 8×4-bit register file. Drives `rs`/`rt`/`sel` into the external combinational ALU, captures its `rd` result and writes it back. It is the instruction-source end of the ALU interface, i.e. the block that produces what the ALU consumes and consumes what it produces.

---
 rtl/alu_issue_sequencer_if.sv | 46 ++++
 rtl/alu_issue_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sequencer_if.sv
// alu_issue_sequencer_if
//   Bundles every non-clock, non-reset signal of the ALU issue sequencer.
//
//   Handshake: an instruction transfers on a rising clk edge where both
//   in_valid and in_ready are high. in_ready depends only on sequencer state,
//   never on in_valid. in_valid/in_instr offered while in_ready is low are
//   ignored (not queued).
//
//   Signals:
//     in_valid, in_ready, in_instr[12:0]   instruction handshake
//     alu_rs[3:0], alu_rt[3:0], alu_sel[2:0]  operands/opcode to external ALU
//     alu_rd[3:0]                          combinational ALU result
//     wb_valid, wb_addr[2:0], wb_data[3:0] one-cycle writeback report
//     busy                                 instruction in flight
//     dbg_addr[2:0], dbg_data[3:0]         register-file debug read
//
//   Modports:
//     master - the sequencer (produces ALU operands, consumes the ALU result)
//     slave  - the environment (instruction source, ALU, debug reader)
interface alu_issue_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_instr;
    logic [3:0]  alu_rs;
    logic [3:0]  alu_rt;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_rd;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [3:0]  wb_data;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [3:0]  dbg_data;

    modport master (
        input  in_valid, in_instr, alu_rd, dbg_addr,
        output in_ready, alu_rs, alu_rt, alu_sel,
               wb_valid, wb_addr, wb_data, busy, dbg_data
    );

    modport slave (
        output in_valid, in_instr, alu_rd, dbg_addr,
        input  in_ready, alu_rs, alu_rt, alu_sel,
               wb_valid, wb_addr, wb_data, busy, dbg_data
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer
//   Issue and writeback controller for the 4-bit decode-and-execute datapath.
//   Accepts one 13-bit instruction at a time, drives operands from an internal
//   8x4 register file into an external combinational ALU, captures the result
//   (or the immediate for loads) and writes it back. One instruction per
//   three cycles: IDLE (accept) -> EXEC (ALU evaluates) -> WB (write + report).
//
//   Instruction: [12] ld, [11:9] op, [8:6] rd, [5:3] rs, [2:0] rt, [3:0] imm.
//
//   Ports:
//     clk  - sole clock, rising edge
//     rst  - synchronous active-high reset (priority over a handshake)
//     bus  - alu_issue_sequencer_if.master (handshake, ALU, writeback, debug)
//
//   Configuration macro ALU_ISSUE_ZERO_REG_EN:
//     defined   - r0 reads as zero and writes to r0 are discarded
//                 (the writeback report still shows the computed value)
//     undefined - r0 is an ordinary register
module alu_issue_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    alu_issue_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [12:0] ir_q;
    logic [3:0]  res_q;
    logic [3:0]  regs [8];
    logic [3:0]  alu_rs_q;
    logic [3:0]  alu_rt_q;
    logic [2:0]  alu_sel_q;

    logic        in_ready_c;
    logic        busy_c;
    logic        wb_valid_c;
    logic        accept;
    logic        rf_we;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [3:0]  dbg_rd;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        busy_c     = 1'b1;
        wb_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                wb_valid_c = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = (state_q == IDLE) && bus.in_valid;

    // ------------------------------------------------------------------
    // Register-file read ports
    // ------------------------------------------------------------------
    // Operands are looked up with the incoming instruction's addresses so the
    // registered ALU inputs are stable for the whole EXEC cycle. Any earlier
    // writeback has already landed: WB always leaves through IDLE, so the
    // accepting edge is at least one edge after the last write.
`ifdef ALU_ISSUE_ZERO_REG_EN
    assign op_a   = (bus.in_instr[5:3] == 3'd0) ? 4'd0 : regs[bus.in_instr[5:3]];
    assign op_b   = (bus.in_instr[2:0] == 3'd0) ? 4'd0 : regs[bus.in_instr[2:0]];
    assign dbg_rd = (bus.dbg_addr == 3'd0) ? 4'd0 : regs[bus.dbg_addr];
    assign rf_we  = (state_q == WB) && (ir_q[8:6] != 3'd0);
`else
    assign op_a   = regs[bus.in_instr[5:3]];
    assign op_b   = regs[bus.in_instr[2:0]];
    assign dbg_rd = regs[bus.dbg_addr];
    assign rf_we  = (state_q == WB);
`endif

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q      <= '0;
            res_q     <= '0;
            alu_rs_q  <= '0;
            alu_rt_q  <= '0;
            alu_sel_q <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept) begin
                ir_q      <= bus.in_instr;
                alu_rs_q  <= op_a;
                alu_rt_q  <= op_b;
                alu_sel_q <= bus.in_instr[11:9];
            end
            // Loads take the immediate; the ALU output is don't-care for them.
            if (state_q == EXEC) begin
                res_q <= ir_q[12] ? ir_q[3:0] : bus.alu_rd;
            end
            if (rf_we) begin
                regs[ir_q[8:6]] <= res_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready = in_ready_c;
    assign bus.busy     = busy_c;
    assign bus.wb_valid = wb_valid_c;
    assign bus.wb_addr  = ir_q[8:6];
    assign bus.wb_data  = res_q;
    assign bus.alu_rs   = alu_rs_q;
    assign bus.alu_rt   = alu_rt_q;
    assign bus.alu_sel  = alu_sel_q;
    assign bus.dbg_data = dbg_rd;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
module tb_alu_issue_sequencer;

    logic clk;
    logic rst;

    alu_issue_sequencer_if bus ();

    alu_issue_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (bus.alu_sel)
            3'd0:    bus.alu_rd = bus.alu_rs + bus.alu_rt;
            3'd1:    bus.alu_rd = bus.alu_rs - bus.alu_rt;
            3'd2:    bus.alu_rd = bus.alu_rs & bus.alu_rt;
            3'd3:    bus.alu_rd = bus.alu_rs | bus.alu_rt;
            3'd4:    bus.alu_rd = {bus.alu_rs[2:0], bus.alu_rs[3]};
            3'd5:    bus.alu_rd = {bus.alu_rt[3], bus.alu_rt[3:1]};
            3'd6:    bus.alu_rd = {3'b111, bus.alu_rs == bus.alu_rt};
            default: bus.alu_rd = {3'b101, bus.alu_rs > bus.alu_rt};
        endcase
    end

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int ref_regs [8];
    logic [3:0] last_wb;
    logic [6:0] exp_q[$];

    function automatic int ref_rd(input logic [2:0] a);
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (a == 3'd0) return 0;
`endif
        return ref_regs[a];
    endfunction

    function automatic void ref_write(input logic [2:0] a, input int v);
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (a == 3'd0) return;
`endif
        ref_regs[a] = v;
    endfunction

    function automatic logic [3:0] model_exec(input logic [12:0] ins);
        int a;
        int b;
        int r;
        if (ins[12]) return ins[3:0];
        a = ref_rd(ins[5:3]);
        b = ref_rd(ins[2:0]);
        case (ins[11:9])
            3'd0:    r = (a + b) % 16;
            3'd1:    r = (a - b + 16) % 16;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = (a * 2) % 16 + a / 8;
            3'd5:    r = b / 2 + ((b >= 8) ? 8 : 0);
            3'd6:    r = 14 + ((a == b) ? 1 : 0);
            default: r = 10 + ((a > b) ? 1 : 0);
        endcase
        return r[3:0];
    endfunction

    function automatic logic [12:0] mk_ld(input logic [2:0] rd, input logic [3:0] imm);
        return {1'b1, 3'b000, rd, 2'b00, imm};
    endfunction

    function automatic logic [12:0] mk_op(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {1'b0, op, rd, rs, rt};
    endfunction

    // driver: one full instruction through IDLE -> EXEC -> WB -> IDLE
    task automatic issue(input logic [12:0] ins, input bit noisy);
        logic [3:0] exp_d;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        int n;
        exp_d = model_exec(ins);
        exp_a = 4'(ref_rd(ins[5:3]));
        exp_b = 4'(ref_rd(ins[2:0]));
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout act=%b req=1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        @(posedge clk); #1;
        // EXEC
        bus.in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_instr = 13'($urandom);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL exec_ctrl act rdy=%b busy=%b wbv=%b req 0 1 0",
                     bus.in_ready, bus.busy, bus.wb_valid);
        end
        vectors++;
        if (bus.alu_rs !== exp_a || bus.alu_rt !== exp_b || bus.alu_sel !== ins[11:9]) begin
            miscompares++;
            $display("FAIL exec_operands act rs=%h rt=%h sel=%0d req rs=%h rt=%h sel=%0d",
                     bus.alu_rs, bus.alu_rt, bus.alu_sel, exp_a, exp_b, ins[11:9]);
        end
        @(posedge clk); #1;
        // WB
        bus.in_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_addr !== ins[8:6] || bus.wb_data !== exp_d
            || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wb act v=%b a=%0d d=%h rdy=%b req v=1 a=%0d d=%h rdy=0",
                     bus.wb_valid, bus.wb_addr, bus.wb_data, bus.in_ready, ins[8:6], exp_d);
        end
        last_wb = bus.wb_data;
        ref_write(ins[8:6], int'(exp_d));
        @(posedge clk); #1;
        // IDLE
        bus.in_valid = 1'b0;
        bus.dbg_addr = ins[8:6];
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ctrl act wbv=%b rdy=%b busy=%b req 0 1 0",
                     bus.wb_valid, bus.in_ready, bus.busy);
        end
        #1;
        vectors++;
        if (bus.dbg_data !== 4'(ref_rd(ins[8:6]))) begin
            miscompares++;
            $display("FAIL dbg_after_wb r%0d act=%h req=%h", ins[8:6], bus.dbg_data,
                     4'(ref_rd(ins[8:6])));
        end
    endtask

    task automatic check_all_regs_zero();
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            vectors++;
            if (bus.dbg_data !== 4'd0) begin
                miscompares++;
                $display("FAIL dbg_zero r%0d act=%h req=0", i, bus.dbg_data);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl act rdy=%b busy=%b wbv=%b req 1 0 0",
                     bus.in_ready, bus.busy, bus.wb_valid);
        end
        vectors++;
        if (bus.wb_addr !== 3'd0 || bus.wb_data !== 4'd0 || bus.alu_rs !== 4'd0
            || bus.alu_rt !== 4'd0 || bus.alu_sel !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_data act wa=%0d wd=%h rs=%h rt=%h sel=%0d req all 0",
                     bus.wb_addr, bus.wb_data, bus.alu_rs, bus.alu_rt, bus.alu_sel);
        end
        check_all_regs_zero();
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    endtask

    task automatic test_load_add();
        issue(mk_ld(3'd1, 4'd5), 1'b0);
        issue(mk_ld(3'd2, 4'd3), 1'b0);
        issue(mk_op(3'd0, 3'd3, 3'd1, 3'd2), 1'b0);
        vectors++;
        if (last_wb !== 4'h8) begin
            miscompares++;
            $display("FAIL add_r3 act=%h req=8", last_wb);
        end
    endtask

    task automatic test_wrap();
        issue(mk_op(3'd1, 3'd4, 3'd2, 3'd1), 1'b0);
        vectors++;
        if (last_wb !== 4'hE) begin
            miscompares++;
            $display("FAIL sub_wrap act=%h req=e", last_wb);
        end
        issue(mk_ld(3'd6, 4'hF), 1'b0);
        issue(mk_op(3'd0, 3'd6, 3'd6, 3'd6), 1'b0);
        vectors++;
        if (last_wb !== 4'hE) begin
            miscompares++;
            $display("FAIL add_wrap act=%h req=e", last_wb);
        end
    endtask

    task automatic test_compare();
        issue(mk_op(3'd7, 3'd5, 3'd1, 3'd2), 1'b0);
        vectors++;
        if (last_wb !== 4'hB) begin
            miscompares++;
            $display("FAIL gt act=%h req=b", last_wb);
        end
        issue(mk_op(3'd6, 3'd5, 3'd1, 3'd1), 1'b0);
        vectors++;
        if (last_wb !== 4'hF) begin
            miscompares++;
            $display("FAIL eq_true act=%h req=f", last_wb);
        end
        issue(mk_op(3'd6, 3'd5, 3'd1, 3'd2), 1'b0);
        vectors++;
        if (last_wb !== 4'hE) begin
            miscompares++;
            $display("FAIL eq_false act=%h req=e", last_wb);
        end
    endtask

    task automatic test_shift();
        issue(mk_op(3'd4, 3'd5, 3'd1, 3'd0), 1'b0);
        vectors++;
        if (last_wb !== 4'hA) begin
            miscompares++;
            $display("FAIL rotl act=%h req=a", last_wb);
        end
        issue(mk_op(3'd5, 3'd5, 3'd0, 3'd4), 1'b0);
        vectors++;
        if (last_wb !== 4'hF) begin
            miscompares++;
            $display("FAIL asr act=%h req=f", last_wb);
        end
    endtask

    task automatic test_handshake_hold();
        logic [12:0] prog [3];
        int hs_cyc[$];
        int idx;
        int since;
        logic hs;
        logic [6:0] got;
        prog[0] = mk_ld(3'($urandom_range(1, 7)), 4'($urandom));
        prog[1] = mk_op(3'($urandom), 3'($urandom), prog[0][8:6], 3'($urandom));
        prog[2] = mk_op(3'($urandom), 3'($urandom), prog[1][8:6], prog[0][8:6]);
        idx = 0;
        since = 99;
        exp_q.delete();
        bus.in_valid = 1'b1;
        bus.in_instr = prog[0];
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (since == 1 || since == 2) begin
                vectors++;
                if (bus.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold_ready_low cyc=%0d act=%b req=0", cyc, bus.in_ready);
                end
            end
            vectors++;
            if (bus.wb_valid !== (since == 2)) begin
                miscompares++;
                $display("FAIL hold_wb_pulse cyc=%0d act=%b req=%b", cyc, bus.wb_valid, since == 2);
            end
            if (bus.wb_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL hold_extra_wb act=%0d:%h req=none", bus.wb_addr, bus.wb_data);
                end else begin
                    got = exp_q.pop_front();
                    if ({bus.wb_addr, bus.wb_data} !== got) begin
                        miscompares++;
                        $display("FAIL hold_wb act=%0d:%h req=%0d:%h",
                                 bus.wb_addr, bus.wb_data, got[6:4], got[3:0]);
                    end
                end
            end
            hs = bus.in_valid && bus.in_ready;
            if (hs) begin
                if (hs_cyc.size() > 0) begin
                    vectors++;
                    if (cyc - hs_cyc[$] != 3) begin
                        miscompares++;
                        $display("FAIL hold_spacing act=%0d req=3", cyc - hs_cyc[$]);
                    end
                end
                hs_cyc.push_back(cyc);
                exp_q.push_back({prog[idx][8:6], model_exec(prog[idx])});
                ref_write(prog[idx][8:6], int'(model_exec(prog[idx])));
                since = 0;
            end
            @(posedge clk); #1;
            since++;
            if (hs) begin
                idx++;
                if (idx == 3) bus.in_valid = 1'b0;
                else          bus.in_instr = prog[idx];
            end
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (hs_cyc.size() != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL hold_count act acc=%0d pend=%0d req acc=3 pend=0",
                     hs_cyc.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [12:0] ins;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) < 3) ins = mk_ld(3'($urandom), 4'($urandom));
            else ins = mk_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            issue(ins, 1'b1);
        end
    endtask

    task automatic test_zero_reg();
        issue(mk_ld(3'd0, 4'd9), 1'b0);
        vectors++;
        if (last_wb !== 4'd9) begin
            miscompares++;
            $display("FAIL ld_r0_wb act=%h req=9", last_wb);
        end
        bus.dbg_addr = 3'd0;
        #1;
        vectors++;
`ifdef ALU_ISSUE_ZERO_REG_EN
        if (bus.dbg_data !== 4'd0) begin
            miscompares++;
            $display("FAIL r0_hardwired act=%h req=0", bus.dbg_data);
        end
`else
        if (bus.dbg_data !== 4'd9) begin
            miscompares++;
            $display("FAIL r0_ordinary act=%h req=9", bus.dbg_data);
        end
`endif
    endtask

    task automatic test_reset_mid();
        issue(mk_ld(3'd1, 4'd5), 1'b0);
        issue(mk_ld(3'd2, 4'd3), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_instr = mk_op(3'd0, 3'd7, 3'd1, 3'd2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_exec_busy act=%b req=1", bus.busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl act wbv=%b rdy=%b busy=%b req 0 1 0",
                     bus.wb_valid, bus.in_ready, bus.busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_late_wb act=%b req=0", bus.wb_valid);
        end
        check_all_regs_zero();
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.dbg_addr = '0;
        last_wb      = '0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        test_reset();
        test_load_add();
        test_wrap();
        test_compare();
        test_shift();
        test_handshake_hold();
        test_random();
        test_zero_reg();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
